devboard_bus_ctl: RTL and testbench
===================================

Name: devboard_bus_ctl

Overview:
Upstream sequencer for the devboard's external multiplexed address/data bus. It accepts single 16-bit read/write requests from the core-side memory port. It drives the address onto the shared AD lines and pulses ALE into the 74FCT573 address latches, then runs the data phase with nRD/nWR strobes and a configurable number of wait states. It also owns the latches' active-low output enable.

Parameters:
LE_CYC, 2, cycles ALE is held high with the address driven (>=1; covers the latch's ~9 ns LE-to-output delay)
WAIT_CYC, 1, extra strobe cycles; nRD/nWR stay low for WAIT_CYC+1 cycles (>=0)
AW, 16, address width latched by the external latches (two 8-bit parts)
DW, 16, data width on the AD bus (DW == AW)

Ports:
clk  in  1  system clock; all state changes on the rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  core request valid
req_ready  out  1  controller can accept a request (IDLE only)
req_we  in  1  1 = write, 0 = read; sampled on accept
req_addr  in  AW  address; sampled on accept
req_wdata  in  DW  write data; sampled on accept
resp_valid  out  1  one-cycle pulse: transfer complete
resp_rdata  out  DW  read data; valid while resp_valid=1 for reads, holds last value otherwise
ad_out  out  DW  value driven onto the AD bus
ad_oe  out  1  1 = controller drives the AD bus; 0 = tristated
ad_in  in  DW  AD bus input for read data
ale  out  1  address latch enable to the 573 LE pins
nrd  out  1  active-low read strobe
nwr  out  1  active-low write strobe
lat_oe_n  out  1  573 output enable, active-low
busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset values: state=IDLE, req_ready=1 (after reset deasserts), resp_valid=0, resp_rdata=0, ad_out=0, ad_oe=0, ale=0, nrd=1, nwr=1, busy=0.
- lat_oe_n=1 while reset is high and 0 from the first edge after reset is released.
- All outputs are registered. There is no combinational path from req_* to any output except req_ready, which is a decode of state.
- FSM states: IDLE -> ADDR -> HOLD -> STROBE -> RECOV -> IDLE.
- IDLE: req_ready=1. On req_valid=1, latch we, addr and wdata into internal registers and go to ADDR. req_ready is 0 in every other state.
- ADDR (LE_CYC cycles): ad_out=addr, ad_oe=1, ale=1.
- HOLD (1 cycle): ale=0; the address is still driven so the hold time at the latches is met.
- STROBE (WAIT_CYC+1 cycles):
  - Read: ad_oe=0, nrd=0. ad_in is registered into resp_rdata at the edge that ends the last STROBE cycle.
  - Write: ad_out=wdata, ad_oe=1, nwr=0.
- RECOV (1 cycle): nrd=1, nwr=1, resp_valid=1.
  - Write: wdata stays driven (data hold after nWR rises).
  - Read: ad_oe stays 0 (bus turnaround).
- Next state after RECOV is IDLE with ad_oe=0.
- nrd and nwr are never both 0. ale is never 1 while nrd=0 or nwr=0.
- Latency: resp_valid is asserted exactly LE_CYC+WAIT_CYC+3 cycles after the accept edge (6 with defaults). Back-to-back throughput is one transfer per LE_CYC+WAIT_CYC+4 cycles.
- A single down-counter, wide enough for max(LE_CYC, WAIT_CYC+1), times the ADDR and STROBE states.
- req_valid held high through a transfer is not accepted again until the controller returns to IDLE. No request queueing.
- Reset mid-operation: at the reset edge, return to IDLE and reset values immediately. No resp_valid is issued for the aborted transfer, and strobes deassert on that same edge.
- Changes on req_addr/req_wdata after accept have no effect on the transfer in progress.

Test Plan:
1. Reset for 3 cycles, then release -> all outputs at reset values during reset; lat_oe_n=0 one cycle after release; req_ready=1.
2. Write addr=0x1234, data=0xBEEF (defaults):
   - ale=1 for 2 cycles with ad_out=0x1234; HOLD cycle with ale=0.
   - nwr=0 for 2 cycles with ad_out=0xBEEF, ad_oe=1.
   - resp_valid pulse 6 cycles after accept.
   - A 573 model on the bus shows 0x1234 after ale falls.
3. Read addr=0x00A5, ad_in model returns 0x5A5A during nrd=0 -> ad_oe=0 throughout STROBE/RECOV; resp_valid pulse with resp_rdata=0x5A5A at accept+6.
4. req_valid held high for two requests (write then read) -> second accept exactly 7 cycles after the first; req_ready=0 between accepts; one resp_valid per transfer.
5. Reset asserted during STROBE of a write -> next edge: nwr=1, ad_oe=0, resp_valid never asserted; a fresh request after release completes normally.
6. WAIT_CYC=0, LE_CYC=1 -> nrd low for exactly 1 cycle; resp_valid at accept+4; ale/strobe overlap never occurs.

Source files
------------

// File: rtl/devboard_bus_ctl_if.sv
// Core-side request/response port plus the multiplexed AD bus pins of the devboard bus controller.
// The controller uses the slave view; the core and the bus-side devices use the master view.
interface devboard_bus_ctl_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic [DW-1:0] ad_out;
  logic          ad_oe;
  logic [DW-1:0] ad_in;
  logic          ale;
  logic          nrd;
  logic          nwr;
  logic          lat_oe_n;
  logic          busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, ad_in,
    input  req_ready, resp_valid, resp_rdata, ad_out, ad_oe, ale, nrd, nwr, lat_oe_n, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ad_in,
    output req_ready, resp_valid, resp_rdata, ad_out, ad_oe, ale, nrd, nwr, lat_oe_n, busy
  );
endinterface

// File: rtl/devboard_bus_ctl.sv
// Sequencer for the devboard multiplexed AD bus: address phase into the 573 latches with ALE,
// then a nRD/nWR data phase with WAIT_CYC extra strobe cycles and a one-cycle recovery.
module devboard_bus_ctl #(
  parameter int LE_CYC   = 2,
  parameter int WAIT_CYC = 1,
  parameter int AW       = 16,
  parameter int DW       = 16
) (
  input logic               clk,
  input logic               reset,
  devboard_bus_ctl_if.slave bus
);

  localparam int CNT_MAX = (LE_CYC > WAIT_CYC + 1) ? LE_CYC : WAIT_CYC + 1;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_HOLD,
    S_STROBE,
    S_RECOV
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [DW-1:0] ad_out_q, ad_out_d;
  logic          ad_oe_q, ad_oe_d;
  logic          ale_q, ale_d;
  logic          nrd_q, nrd_d;
  logic          nwr_q, nwr_d;
  logic          resp_valid_q, resp_valid_d;
  logic          busy_q, busy_d;
  logic          lat_oe_n_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = CW'(LE_CYC - 1);
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (cnt_q == '0) state_d = S_HOLD;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_HOLD: begin
        cnt_d   = CW'(WAIT_CYC);
        state_d = S_STROBE;
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          state_d = S_RECOV;
          if (!we_q) rdata_d = bus.ad_in;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RECOV: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Pin values are decoded from the next state so every output leaves a flop.
    ad_out_d     = ad_out_q;
    ad_oe_d      = 1'b0;
    ale_d        = 1'b0;
    nrd_d        = 1'b1;
    nwr_d        = 1'b1;
    resp_valid_d = (state_d == S_RECOV);
    busy_d       = (state_d != S_IDLE);

    unique case (state_d)
      S_ADDR, S_HOLD: begin
        ad_out_d = addr_d;
        ad_oe_d  = 1'b1;
        ale_d    = (state_d == S_ADDR);
      end
      S_STROBE: begin
        if (we_d) begin
          ad_out_d = wdata_d;
          ad_oe_d  = 1'b1;
          nwr_d    = 1'b0;
        end else begin
          nrd_d = 1'b0;
        end
      end
      S_RECOV: begin
        // Writes keep data on the bus past the nWR rising edge; reads stay tristated for turnaround.
        if (we_d) begin
          ad_out_d = wdata_d;
          ad_oe_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      ad_out_q     <= '0;
      ad_oe_q      <= 1'b0;
      ale_q        <= 1'b0;
      nrd_q        <= 1'b1;
      nwr_q        <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      lat_oe_n_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      ad_out_q     <= ad_out_d;
      ad_oe_q      <= ad_oe_d;
      ale_q        <= ale_d;
      nrd_q        <= nrd_d;
      nwr_q        <= nwr_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
      lat_oe_n_q   <= 1'b0;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.ad_out     = ad_out_q;
  assign bus.ad_oe      = ad_oe_q;
  assign bus.ale        = ale_q;
  assign bus.nrd        = nrd_q;
  assign bus.nwr        = nwr_q;
  assign bus.lat_oe_n   = lat_oe_n_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_devboard_bus_ctl.sv
// Bench for devboard_bus_ctl: a default-timing and a LE_CYC=1/WAIT_CYC=0 controller share one request
// stream; each has a 573 + memory model on its bus and an offset-based reference model checked every cycle.
module tb_devboard_bus_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [15:0] req_addr, req_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  logic        ale_v [2], nrd_v [2], nwr_v [2], oe_v [2], rv_v [2], rdy_v [2], busy_v [2], loen_v [2];
  logic [15:0] ad_v [2], rd_v [2], lat_v [2];

  logic [15:0] h_ale [2], h_nrd [2], h_nwr [2], h_oe [2], h_rv [2], h_rdy [2], h_busy [2];
  logic [15:0] h_ad [2][16], h_rd [2][16], h_lat [2][16];

  function automatic logic [15:0] dflt(input logic [15:0] a);
    return (a == 16'h00A5) ? 16'h5A5A : ~a;
  endfunction

  task automatic chk1(input int cfg, input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL cfg%0d %s: got %b expected %b @%0t", cfg, nm, act, exp, $time);
    end
  endtask

  task automatic chk16(input int cfg, input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL cfg%0d %s: got %h expected %h @%0t", cfg, nm, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int LE = (gi == 0) ? 2 : 1;
    localparam int WC = (gi == 0) ? 1 : 0;
    localparam int T  = LE + WC + 3;

    devboard_bus_ctl_if #(.AW(16), .DW(16)) bus_if ();

    devboard_bus_ctl #(.LE_CYC(LE), .WAIT_CYC(WC), .AW(16), .DW(16)) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus_if)
    );

    logic [15:0] lat_q = '0;
    logic [15:0] ad_in_r = '0;
    logic        nwr_prev = 1'b1;
    logic        rst_at_edge = 1'b1;
    logic [15:0] dev_mem [logic [15:0]];

    assign bus_if.req_valid = req_valid;
    assign bus_if.req_we    = req_we;
    assign bus_if.req_addr  = req_addr;
    assign bus_if.req_wdata = req_wdata;
    assign bus_if.ad_in     = ad_in_r;

    assign ale_v[gi]  = bus_if.ale;
    assign nrd_v[gi]  = bus_if.nrd;
    assign nwr_v[gi]  = bus_if.nwr;
    assign oe_v[gi]   = bus_if.ad_oe;
    assign rv_v[gi]   = bus_if.resp_valid;
    assign rdy_v[gi]  = bus_if.req_ready;
    assign busy_v[gi] = bus_if.busy;
    assign loen_v[gi] = bus_if.lat_oe_n;
    assign ad_v[gi]   = bus_if.ad_out;
    assign rd_v[gi]   = bus_if.resp_rdata;
    assign lat_v[gi]  = lat_q;

    // External side: transparent 573 latch, memory written on nWR rising, read data driven while nRD is low.
    always @(posedge clk) rst_at_edge = reset;

    always @(negedge clk) begin
      if (bus_if.ale) lat_q = bus_if.ad_out;
      if (bus_if.nwr && !nwr_prev && !rst_at_edge) dev_mem[lat_q] = bus_if.ad_out;
      nwr_prev = bus_if.nwr;
      if (!bus_if.nrd && !bus_if.lat_oe_n)
        ad_in_r = dev_mem.exists(lat_q) ? dev_mem[lat_q] : dflt(lat_q);
      else
        ad_in_r = 16'($urandom);
    end

    // Reference: k counts cycles since the accept edge (0 = idle); phases follow from LE/WC arithmetic.
    int          k = 0;
    logic        m_we = 1'b0;
    logic [15:0] m_addr = '0, m_wdata = '0, exp_rdata = '0;
    logic        exp_loen = 1'b1;
    bit          seen = 1'b0;
    logic [15:0] m_mem [logic [15:0]];
    bit          in_a, in_h, in_s, in_r, drv;

    always @(posedge clk) begin
      seen     = 1'b1;
      exp_loen = reset;
      if (reset) begin
        k         = 0;
        exp_rdata = '0;
      end else if (k == 0) begin
        if (req_valid) begin
          k       = 1;
          m_we    = req_we;
          m_addr  = req_addr;
          m_wdata = req_wdata;
        end
      end else begin
        if (k == LE + WC + 2) begin
          if (m_we) m_mem[m_addr] = m_wdata;
          else      exp_rdata = m_mem.exists(m_addr) ? m_mem[m_addr] : dflt(m_addr);
        end
        k = (k == T) ? 0 : k + 1;
      end
    end

    always @(negedge clk) begin
      if (seen) begin
        in_a = (k >= 1 && k <= LE);
        in_h = (k == LE + 1);
        in_s = (k >= LE + 2 && k <= LE + WC + 2);
        in_r = (k == T);
        drv  = in_a || in_h || (m_we && (in_s || in_r));
        chk1(gi, "ale", bus_if.ale, in_a);
        chk1(gi, "ad_oe", bus_if.ad_oe, drv);
        chk1(gi, "nrd", bus_if.nrd, !(in_s && !m_we));
        chk1(gi, "nwr", bus_if.nwr, !(in_s && m_we));
        chk1(gi, "resp_valid", bus_if.resp_valid, in_r);
        chk1(gi, "busy", bus_if.busy, k != 0);
        chk1(gi, "req_ready", bus_if.req_ready, k == 0);
        chk1(gi, "lat_oe_n", bus_if.lat_oe_n, exp_loen);
        chk16(gi, "resp_rdata", bus_if.resp_rdata, exp_rdata);
        if (in_a || in_h) chk16(gi, "ad_out_addr", bus_if.ad_out, m_addr);
        else if (drv)     chk16(gi, "ad_out_data", bus_if.ad_out, m_wdata);
      end
    end
  end

  task automatic clear_hist();
    for (int c = 0; c < 2; c++) begin
      h_ale[c] = '0; h_nrd[c] = '0; h_nwr[c] = '0; h_oe[c] = '0;
      h_rv[c] = '0; h_rdy[c] = '0; h_busy[c] = '0;
      for (int j = 0; j < 16; j++) begin
        h_ad[c][j] = '0; h_rd[c][j] = '0; h_lat[c][j] = '0;
      end
    end
  endtask

  task automatic cap(input int j);
    for (int c = 0; c < 2; c++) begin
      h_ale[c][j] = ale_v[c];  h_nrd[c][j] = nrd_v[c];  h_nwr[c][j] = nwr_v[c];
      h_oe[c][j] = oe_v[c];    h_rv[c][j] = rv_v[c];    h_rdy[c][j] = rdy_v[c];
      h_busy[c][j] = busy_v[c];
      h_ad[c][j] = ad_v[c];    h_rd[c][j] = rd_v[c];    h_lat[c][j] = lat_v[c];
    end
  endtask

  // Records cycles 1..n after the next accept edge, with scripted request/reset changes.
  task automatic run(input int n, input int drop_at, input int rd_at, input int rst_on, input int rst_off);
    clear_hist();
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      cap(j);
      if (j == rd_at) req_we = 1'b0;
      if (j == drop_at) begin
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
      end
      if (j == rst_on)  reset = 1'b1;
      if (j == rst_off) reset = 1'b0;
    end
  endtask

  int rst_left = 0;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      chk1(c, "rst_ale", ale_v[c], 1'b0);
      chk1(c, "rst_nrd", nrd_v[c], 1'b1);
      chk1(c, "rst_nwr", nwr_v[c], 1'b1);
      chk1(c, "rst_oe", oe_v[c], 1'b0);
      chk1(c, "rst_rv", rv_v[c], 1'b0);
      chk1(c, "rst_busy", busy_v[c], 1'b0);
      chk1(c, "rst_loen", loen_v[c], 1'b1);
      chk16(c, "rst_ad", ad_v[c], 16'h0000);
      chk16(c, "rst_rd", rd_v[c], 16'h0000);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      chk1(c, "rel_loen", loen_v[c], 1'b0);
      chk1(c, "rel_ready", rdy_v[c], 1'b1);
    end

    // Write 0x1234 <= 0xBEEF
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h1234; req_wdata = 16'hBEEF;
    run(7, 1, 0, 0, 0);
    chk16(0, "wr_ale", h_ale[0], 16'h0006);
    chk16(0, "wr_nwr", h_nwr[0], 16'h00CE);
    chk16(0, "wr_oe", h_oe[0], 16'h007E);
    chk16(0, "wr_rv", h_rv[0], 16'h0040);
    chk16(0, "wr_ad_addr", h_ad[0][1], 16'h1234);
    chk16(0, "wr_ad_data", h_ad[0][4], 16'hBEEF);
    chk16(0, "wr_ad_hold", h_ad[0][6], 16'hBEEF);
    chk16(0, "wr_latch", h_lat[0][3], 16'h1234);
    chk16(1, "wr_ale", h_ale[1], 16'h0002);
    chk16(1, "wr_nwr", h_nwr[1], 16'h00F6);
    chk16(1, "wr_rv", h_rv[1], 16'h0010);

    // Read 0x00A5 -> 0x5A5A from the bus device
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h00A5;
    run(7, 1, 0, 0, 0);
    chk16(0, "rd_oe", h_oe[0], 16'h000E);
    chk16(0, "rd_nrd", h_nrd[0], 16'h00CE);
    chk16(0, "rd_nwr", h_nwr[0], 16'h00FE);
    chk16(0, "rd_rv", h_rv[0], 16'h0040);
    chk16(0, "rd_data", h_rd[0][6], 16'h5A5A);
    chk16(1, "rd_nrd", h_nrd[1], 16'h00F6);
    chk16(1, "rd_rv", h_rv[1], 16'h0010);
    chk16(1, "rd_data", h_rd[1][4], 16'h5A5A);

    // req_valid held: write 0x0F0F <= 0x1357, then read it back
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0F0F; req_wdata = 16'h1357;
    run(14, 8, 1, 0, 0);
    chk16(0, "b2b_ready", h_rdy[0], 16'h4080);
    chk16(0, "b2b_rv", h_rv[0], 16'h2040);
    chk16(0, "b2b_rdata", h_rd[0][13], 16'h1357);
    chk16(1, "b2b_ready", h_rdy[1], 16'h7C20);
    chk16(1, "b2b_rv", h_rv[1], 16'h0210);
    chk16(1, "b2b_rdata", h_rd[1][9], 16'h1357);

    // Reset during the write strobe of the default-timing controller
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h2222; req_wdata = 16'h3333;
    run(6, 1, 0, 4, 6);
    chk1(0, "abort_nwr_low", h_nwr[0][4], 1'b0);
    chk1(0, "abort_nwr_rel", h_nwr[0][5], 1'b1);
    chk1(0, "abort_oe", h_oe[0][5], 1'b0);
    chk1(0, "abort_busy", h_busy[0][5], 1'b0);
    chk16(0, "abort_rv", h_rv[0], 16'h0000);
    chk16(1, "abort_rv", h_rv[1], 16'h0010);

    // Fresh transfer after the abort
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h4444; req_wdata = 16'h5555;
    run(7, 1, 0, 0, 0);
    chk16(0, "fresh_rv", h_rv[0], 16'h0040);
    chk16(1, "fresh_rv", h_rv[1], 16'h0010);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (rst_left > 0) begin
        reset = 1'b1;
        rst_left--;
      end else begin
        reset = 1'b0;
        if ($urandom_range(0, 99) == 0) rst_left = 2;
      end
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = 1'($urandom);
      req_addr  = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 7));
      req_wdata = 16'($urandom);
    end
    reset = 1'b0;
    req_valid = 1'b0;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
